// File: rtl/int_alu_pkg.sv
// int_alu shared definitions: opcodes, register map, module selects
// and the one-cycle ALU helper.
package int_alu_pkg;

  localparam logic [7:0] OP_ADD = 8'h10;
  localparam logic [7:0] OP_SUB = 8'h11;
  localparam logic [7:0] OP_MUL = 8'h12;
  localparam logic [7:0] OP_DIV = 8'h13;
  localparam logic [7:0] OP_AND = 8'h14;
  localparam logic [7:0] OP_OR  = 8'h15;
  localparam logic [7:0] OP_XOR = 8'h16;

  localparam logic [11:0] REG_SRC1       = 12'd0;
  localparam logic [11:0] REG_SRC2       = 12'd1;
  localparam logic [11:0] REG_RESULT     = 12'd2;
  localparam logic [11:0] REG_STATUS_IN  = 12'd3;
  localparam logic [11:0] REG_STATUS_OUT = 12'd4;

  localparam logic [3:0] MSEL_ENGINE  = 4'h0;
  localparam logic [3:0] MSEL_MEM     = 4'h1;
  localparam logic [3:0] MSEL_IO      = 4'h2;
  localparam logic [3:0] MSEL_INT_ALU = 4'h3;
  localparam logic [3:0] MSEL_FPU     = 4'h4;
  localparam logic [3:0] MSEL_AUX     = 4'h5;

  localparam int DW  = 256;
  localparam int OPW = 32;

  typedef enum logic [1:0] {
    IDLE,
    EXEC1,
    ITERATE,
    DONE
  } state_e;

  function automatic logic is_iter_op(
    input logic [7:0] op
  );
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

  function automatic logic [63:0] exec1_fn(
    input logic [7:0]     op,
    input logic [OPW-1:0] a,
    input logic [OPW-1:0] b
  );
    logic [63:0] r;
    r = '0;
    case (op)
      OP_ADD: r[32:0] = {1'b0, a} + {1'b0, b};
      // 33-bit difference: bit 32 is the borrow
      OP_SUB: r[32:0] = {1'b0, a} - {1'b0, b};
      OP_AND: r[31:0] = a & b;
      OP_OR:  r[31:0] = a | b;
      OP_XOR: r[31:0] = a ^ b;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/int_alu_iter.sv
// Shared iterative datapath: shift-add multiply and restoring divide.
// One step per cycle after start; done flags the final step.
module int_alu_iter
  import int_alu_pkg::*;
#(
  parameter int ITER = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start_i,
  input  logic           op_is_div_i,
  input  logic [OPW-1:0] a_i,
  input  logic [OPW-1:0] b_i,
  output logic           done_o,
  output logic [63:0]    result_o
);

  localparam int CW = $clog2(ITER + 1);

  logic          busy_q;
  logic [CW-1:0] cnt_q;
  logic          div_q;
  logic [63:0]   acc_q, acc_d;
  logic [31:0]   x_q, x_d;
  logic [63:0]   y_q, y_d;

  logic [32:0] shifted;
  logic [33:0] diff;

  // acc: product / remainder; x: multiplier / dividend-quotient;
  // y: shifting multiplicand / divisor
  always_comb begin
    acc_d   = acc_q;
    x_d     = x_q;
    y_d     = y_q;
    shifted = {acc_q[31:0], x_q[31]};
    diff    = {1'b0, shifted} - {2'b00, y_q[31:0]};
    if (div_q) begin
      if (!diff[33]) begin
        acc_d = {31'b0, diff[32:0]};
        x_d   = {x_q[30:0], 1'b1};
      end else begin
        acc_d = {32'b0, shifted[31:0]};
        x_d   = {x_q[30:0], 1'b0};
      end
    end else begin
      acc_d = acc_q + (x_q[0] ? y_q : 64'h0);
      x_d   = x_q >> 1;
      y_d   = y_q << 1;
    end
  end

  assign done_o   = busy_q && (cnt_q == CW'(1));
  assign result_o = div_q ? {acc_d[31:0], x_d} : acc_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      div_q  <= 1'b0;
      acc_q  <= '0;
      x_q    <= '0;
      y_q    <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      cnt_q  <= CW'(ITER);
      div_q  <= op_is_div_i;
      acc_q  <= '0;
      x_q    <= a_i;
      y_q    <= {32'b0, b_i};
    end else if (busy_q) begin
      acc_q <= acc_d;
      x_q   <= x_d;
      y_q   <= y_d;
      cnt_q <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/int_alu.sv
// Memory-mapped integer ALU: register file, bus decode and
// control FSM around the iterative multiply/divide unit.
module int_alu
  import int_alu_pkg::*;
#(
  parameter logic [3:0] MODULE_SEL = MSEL_INT_ALU,
  parameter int         ITER       = 32
) (
  input  logic          Clk,
  input  logic          nReset,
  input  logic [15:0]   address,
  input  logic          nRead,
  input  logic          nWrite,
  input  logic [DW-1:0] ExeDataOut,
  output logic [DW-1:0] IntDataOut
);

  logic          sel;
  logic [11:0]   idx;
  logic          busy;
  logic          wr_ok;
  logic          start;
  logic          iter_start;
  logic          iter_done;
  logic [63:0]   iter_result;

  state_e        state_q, state_d;
  logic [DW-1:0] src1_q, src1_d;
  logic [DW-1:0] src2_q, src2_d;
  logic [63:0]   result_q, result_d;
  logic          status_q, status_d;
  logic [7:0]    op_q, op_d;
  logic [31:0]   a_q, a_d;
  logic [31:0]   b_q, b_d;

  assign sel   = (address[15:12] == MODULE_SEL);
  assign idx   = address[11:0];
  assign busy  = (state_q == EXEC1) || (state_q == ITERATE);
  assign wr_ok = sel && !nWrite && !busy;
  assign start = wr_ok && (idx == REG_STATUS_IN);

  assign iter_start = start && is_iter_op(ExeDataOut[7:0]);

  int_alu_iter #(
    .ITER(ITER)
  ) u_iter (
    .clk        (Clk),
    .rst_n      (nReset),
    .start_i    (iter_start),
    .op_is_div_i(ExeDataOut[7:0] == OP_DIV),
    .a_i        (src1_q[31:0]),
    .b_i        (src2_q[31:0]),
    .done_o     (iter_done),
    .result_o   (iter_result)
  );

  always_comb begin
    src1_d = src1_q;
    src2_d = src2_q;
    if (wr_ok && (idx == REG_SRC1)) begin
      src1_d = ExeDataOut;
    end
    if (wr_ok && (idx == REG_SRC2)) begin
      src2_d = ExeDataOut;
    end
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    status_d = status_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          op_d     = ExeDataOut[7:0];
          a_d      = src1_q[31:0];
          b_d      = src2_q[31:0];
          status_d = 1'b0;
          state_d  = is_iter_op(ExeDataOut[7:0]) ? ITERATE : EXEC1;
        end
      end
      EXEC1: begin
        result_d = exec1_fn(op_q, a_q, b_q);
        status_d = 1'b1;
        state_d  = DONE;
      end
      ITERATE: begin
        if (iter_done) begin
          result_d = iter_result;
          status_d = 1'b1;
          state_d  = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q  <= IDLE;
      src1_q   <= '0;
      src2_q   <= '0;
      result_q <= '0;
      status_q <= 1'b0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
    end else begin
      state_q  <= state_d;
      src1_q   <= src1_d;
      src2_q   <= src2_d;
      result_q <= result_d;
      status_q <= status_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
    end
  end

  always_comb begin
    IntDataOut = '0;
    if (sel && !nRead) begin
      case (idx)
        REG_SRC1:       IntDataOut = src1_q;
        REG_SRC2:       IntDataOut = src2_q;
        REG_RESULT:     IntDataOut = {192'b0, result_q};
        REG_STATUS_OUT: IntDataOut = {255'b0, status_q};
        default:        IntDataOut = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_int_alu.sv
// Scoreboard bench for int_alu: bus tasks driven on negedge,
// expected results queued at start and popped on completion.
module tb_int_alu;

  localparam logic [3:0]  SEL  = 4'h3;
  localparam logic [11:0] I_S1 = 12'd0;
  localparam logic [11:0] I_S2 = 12'd1;
  localparam logic [11:0] I_RS = 12'd2;
  localparam logic [11:0] I_SI = 12'd3;
  localparam logic [11:0] I_SO = 12'd4;

  logic         Clk;
  logic         nReset;
  logic [15:0]  address;
  logic         nRead;
  logic         nWrite;
  logic [255:0] ExeDataOut;
  logic [255:0] IntDataOut;

  int n_checks;
  int n_fail;
  logic [255:0] sb[$];
  logic [255:0] d;

  int_alu dut (
    .Clk       (Clk),
    .nReset    (nReset),
    .address   (address),
    .nRead     (nRead),
    .nWrite    (nWrite),
    .ExeDataOut(ExeDataOut),
    .IntDataOut(IntDataOut)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [255:0] model(
    input logic [7:0]  op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [255:0] r;
    r = '0;
    case (op)
      8'h10: r[32:0] = 33'(a) + 33'(b);
      8'h11: begin
        r[31:0] = a - b;
        r[32]   = (a < b);
      end
      8'h12: r[63:0] = 64'(a) * 64'(b);
      8'h13: begin
        if (b == 0) r[63:0] = {a, 32'hFFFF_FFFF};
        else        r[63:0] = {a % b, a / b};
      end
      8'h14: r[31:0] = a & b;
      8'h15: r[31:0] = a | b;
      8'h16: r[31:0] = a ^ b;
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic rd(input logic [11:0] idx, output logic [255:0] v);
    address = {SEL, idx};
    nRead   = 1'b0;
    #1 v    = IntDataOut;
    nRead   = 1'b1;
  endtask

  task automatic wr(input logic [11:0] idx, input logic [255:0] v);
    address    = {SEL, idx};
    ExeDataOut = v;
    nWrite     = 1'b0;
    @(negedge Clk);
    nWrite     = 1'b1;
  endtask

  task automatic start_op(input logic [7:0] op,
                          input logic [255:0] a,
                          input logic [255:0] b);
    wr(I_S1, a);
    wr(I_S2, b);
    sb.push_back(model(op, a[31:0], b[31:0]));
    wr(I_SI, {248'b0, op});
  endtask

  task automatic wait_and_check(input string name);
    logic [255:0] v;
    logic [255:0] e;
    bit hit;
    hit = 0;
    for (int i = 0; i < 40; i++) begin
      rd(I_SO, v);
      if (v === 256'h1) begin
        hit = 1;
        break;
      end
      cyc(1);
    end
    n_checks++;
    if (!hit) begin
      n_fail++;
      $display("FAIL %s_timeout status got %0h exp 1", name, v);
    end
    rd(I_RS, v);
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s_result got %0h exp <empty scoreboard>", name, v);
    end else begin
      e = sb.pop_front();
      if (v !== e) begin
        n_fail++;
        $display("FAIL %s_result got %0h exp %0h", name, v, e);
      end
    end
  endtask

  task automatic test_reset;
    nReset = 1'b0;
    cyc(2);
    nReset = 1'b1;
    cyc(1);
    for (int i = 0; i < 6; i++) begin
      rd(12'(i), d);
      n_checks++;
      if (d !== 256'h0) begin
        n_fail++;
        $display("FAIL reset_idx%0d got %0h exp 0", i, d);
      end
    end
    wr(I_S1, 256'hABCD);
    address = {SEL, I_S1};
    #1;
    n_checks++;
    if (IntDataOut !== 256'h0) begin
      n_fail++;
      $display("FAIL nread_high got %0h exp 0", IntDataOut);
    end
    address = {4'h2, I_S1};
    nRead = 1'b0;
    #1;
    n_checks++;
    if (IntDataOut !== 256'h0) begin
      n_fail++;
      $display("FAIL unselected_read got %0h exp 0", IntDataOut);
    end
    nRead = 1'b1;
    address = {4'h2, I_S2};
    ExeDataOut = 256'h77;
    nWrite = 1'b0;
    cyc(1);
    nWrite = 1'b1;
    rd(I_S2, d);
    n_checks++;
    if (d !== 256'h0) begin
      n_fail++;
      $display("FAIL unselected_write got %0h exp 0", d);
    end
  endtask

  task automatic test_add;
    start_op(8'h10, 256'hFFFF_FFFF, 256'h1);
    rd(I_SO, d);
    n_checks++;
    if (d !== 256'h0) begin
      n_fail++;
      $display("FAIL add_busy got %0h exp 0", d);
    end
    cyc(1);
    rd(I_SO, d);
    n_checks++;
    if (d !== 256'h1) begin
      n_fail++;
      $display("FAIL add_done got %0h exp 1", d);
    end
    wait_and_check("add");
  endtask

  task automatic test_sub;
    start_op(8'h11, 256'd5, 256'd7);
    wait_and_check("sub");
    start_op(8'h11, 256'd9, 256'd4);
    wait_and_check("sub_noborrow");
  endtask

  task automatic test_mul;
    start_op(8'h12, 256'h0001_0000, 256'h0001_0000);
    for (int k = 0; k < 32; k++) begin
      if (k > 0) cyc(1);
      rd(I_SO, d);
      n_checks++;
      if (d !== 256'h0) begin
        n_fail++;
        $display("FAIL mul_poll%0d got %0h exp 0", k, d);
      end
    end
    cyc(1);
    rd(I_SO, d);
    n_checks++;
    if (d !== 256'h1) begin
      n_fail++;
      $display("FAIL mul_done32 got %0h exp 1", d);
    end
    wait_and_check("mul");
    start_op(8'h12, 256'hFFFF_FFFF, 256'hFFFF_FFFF);
    wait_and_check("mul_max");
  endtask

  task automatic test_div;
    start_op(8'h13, 256'd100, 256'd7);
    wait_and_check("div");
    start_op(8'h13, 256'd100, 256'd0);
    wait_and_check("div_by0");
    start_op(8'h13, 256'hFFFF_FFFF, 256'h8000_0001);
    wait_and_check("div_big");
  endtask

  task automatic test_logic;
    logic [7:0] ops[4];
    ops = '{8'h14, 8'h15, 8'h16, 8'h20};
    for (int i = 0; i < 4; i++) begin
      start_op(ops[i], {224'h5A5A, 32'hF0F0_1234},
               {224'hA5A5, 32'h0FF0_5678});
      wait_and_check($sformatf("logic_%0h", ops[i]));
    end
  endtask

  task automatic test_rw_same_cycle;
    wr(I_S2, 256'h11);
    address    = {SEL, I_S2};
    ExeDataOut = 256'h22;
    nWrite     = 1'b0;
    nRead      = 1'b0;
    #1;
    n_checks++;
    if (IntDataOut !== 256'h11) begin
      n_fail++;
      $display("FAIL rw_pre_edge got %0h exp 11", IntDataOut);
    end
    cyc(1);
    nWrite = 1'b1;
    nRead  = 1'b1;
    rd(I_S2, d);
    n_checks++;
    if (d !== 256'h22) begin
      n_fail++;
      $display("FAIL rw_post_edge got %0h exp 22", d);
    end
  endtask

  task automatic test_back_to_back;
    logic [255:0] e;
    start_op(8'h10, 256'd10, 256'd20);
    wr(I_SI, 256'h11);
    rd(I_RS, d);
    e = sb.pop_front();
    n_checks++;
    if (d !== e) begin
      n_fail++;
      $display("FAIL b2b_first got %0h exp %0h", d, e);
    end
    sb.push_back(model(8'h16, 32'd10, 32'd20));
    wr(I_SI, 256'h16);
    wait_and_check("b2b_second");
  endtask

  task automatic test_reset_mid;
    start_op(8'h12, 256'd3, 256'd4);
    cyc(4);
    wr(I_S1, 256'd9);
    rd(I_S1, d);
    n_checks++;
    if (d !== 256'd3) begin
      n_fail++;
      $display("FAIL busy_write_ignored got %0h exp 3", d);
    end
    cyc(4);
    nReset = 1'b0;
    cyc(1);
    nReset = 1'b1;
    sb.delete();
    for (int i = 0; i < 5; i++) begin
      rd(12'(i), d);
      n_checks++;
      if (d !== 256'h0) begin
        n_fail++;
        $display("FAIL midreset_idx%0d got %0h exp 0", i, d);
      end
    end
    cyc(35);
    rd(I_SO, d);
    n_checks++;
    if (d !== 256'h0) begin
      n_fail++;
      $display("FAIL midreset_no_done got %0h exp 0", d);
    end
    start_op(8'h10, 256'd40, 256'd2);
    wait_and_check("add_after_reset");
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    nReset     = 1'b0;
    nRead      = 1'b1;
    nWrite     = 1'b1;
    address    = '0;
    ExeDataOut = '0;
    @(negedge Clk);
    test_reset;
    test_add;
    test_sub;
    test_mul;
    test_div;
    test_logic;
    test_rw_same_cycle;
    test_back_to_back;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
